// File: rtl/img_pkg.sv
// Shared frame-buffer definitions: image geometry, reply codes and
// the state type of the UART upload controller.
package img_pkg;

    localparam int unsigned IMG_W  = 640;
    localparam int unsigned IMG_H  = 480;
    localparam int unsigned NPIX   = IMG_W * IMG_H;
    localparam int unsigned ADDR_W = 19;

    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SYNC1,
        ST_LOAD,
        ST_REPLY
    } loader_state_t;

endpackage

// File: rtl/uart_frame_loader.sv
// UART upload controller: waits for a two-byte sync header, writes one
// frame of pixels to sequential buffer addresses, then replies ACK, or
// NAK if the pixel stream goes quiet for too long.
module uart_frame_loader #(
    parameter int unsigned IMG_W       = img_pkg::IMG_W,
    parameter int unsigned IMG_H       = img_pkg::IMG_H,
    parameter logic [7:0]  SYNC0       = 8'hA5,
    parameter logic [7:0]  SYNC1       = 8'h5A,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        abort,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    output logic        buf_we,
    output logic [18:0] buf_addr,
    output logic [7:0]  buf_data,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err
);
    import img_pkg::*;

    localparam int unsigned FRAME_PIX = IMG_W * IMG_H;
    localparam int unsigned IDLE_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
    localparam logic [IDLE_W-1:0] TO_LAST   = IDLE_W'(TIMEOUT_CYC - 1);

    loader_state_t     state, state_next;
    logic [ADDR_W-1:0] pixel_cnt, pixel_next;
    logic [IDLE_W-1:0] idle_cnt, idle_next;
    logic              wr_pix;
    logic              last_pix;
    logic              tmo_fire;
    logic [7:0]        reply_next;

    // Next-state decode plus the per-cycle write/done/timeout events.
    always_comb begin
        state_next = state;
        pixel_next = pixel_cnt;
        idle_next  = '0;
        wr_pix     = 1'b0;
        last_pix   = 1'b0;
        tmo_fire   = 1'b0;
        reply_next = tx_data;

        case (state)
            ST_IDLE: begin
                if (rx_valid && rx_data == SYNC0) begin
                    state_next = ST_SYNC1;
                end
            end

            ST_SYNC1: begin
                if (rx_valid) begin
                    if (rx_data == SYNC1) begin
                        state_next = ST_LOAD;
                        pixel_next = '0;
                    end else if (rx_data != SYNC0) begin
                        state_next = ST_IDLE;
                    end
                end
            end

            ST_LOAD: begin
                // A byte arriving on the terminal idle count still wins.
                if (rx_valid) begin
                    wr_pix     = 1'b1;
                    pixel_next = pixel_cnt + 1'b1;
                    if (pixel_cnt == LAST_ADDR) begin
                        last_pix   = 1'b1;
                        reply_next = ACK;
                        state_next = ST_REPLY;
                    end
                end else if (idle_cnt == TO_LAST) begin
                    tmo_fire   = 1'b1;
                    reply_next = NAK;
                    state_next = ST_REPLY;
                end else begin
                    idle_next = idle_cnt + 1'b1;
                end
            end

            ST_REPLY: begin
                if (tx_valid && tx_ready) begin
                    state_next = ST_IDLE;
                end
            end

            default: state_next = ST_IDLE;
        endcase

        // Abort overrides everything decoded above, including a byte
        // arriving in the same cycle.
        if (abort) begin
            state_next = ST_IDLE;
            pixel_next = pixel_cnt;
            idle_next  = '0;
            wr_pix     = 1'b0;
            last_pix   = 1'b0;
            tmo_fire   = 1'b0;
            reply_next = tx_data;
        end
    end

    // State, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            pixel_cnt   <= '0;
            idle_cnt    <= '0;
            tx_data     <= '0;
            tx_valid    <= 1'b0;
            buf_we      <= 1'b0;
            buf_addr    <= '0;
            buf_data    <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_next;
            pixel_cnt   <= pixel_next;
            idle_cnt    <= idle_next;
            tx_data     <= reply_next;
            // tx_valid trails REPLY entry by a cycle, so it rises one cycle
            // after frame_done / timeout_err and drops on the handshake.
            tx_valid    <= (state == ST_REPLY) && (state_next == ST_REPLY);
            buf_we      <= wr_pix;
            busy        <= (state_next != ST_IDLE);
            frame_done  <= last_pix;
            timeout_err <= tmo_fire;
            if (wr_pix) begin
                buf_addr <= pixel_cnt;
                buf_data <= rx_data;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_loader.sv
// Self-checking bench for uart_frame_loader with a reduced frame size:
// a write scoreboard fed by the stimulus, plus cycle-exact checks of the
// reply, timeout and abort behaviour.
module tb_uart_frame_loader;

    localparam int unsigned W       = 16;
    localparam int unsigned H       = 8;
    localparam int unsigned NPX     = W * H;
    localparam int unsigned TMO     = 100;
    localparam logic [7:0]  S0      = 8'hA5;
    localparam logic [7:0]  S1      = 8'h5A;
    localparam logic [7:0]  ACK_B   = 8'h06;
    localparam logic [7:0]  NAK_B   = 8'h15;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        abort;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        buf_we;
    logic [18:0] buf_addr;
    logic [7:0]  buf_data;
    logic        busy;
    logic        frame_done;
    logic        timeout_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [26:0] exp_wr[$];
    logic        tx_expected  = 1'b0;
    logic        tmo_expected = 1'b0;

    uart_frame_loader #(
        .IMG_W      (W),
        .IMG_H      (H),
        .SYNC0      (S0),
        .SYNC1      (S1),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .abort      (abort),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .buf_we     (buf_we),
        .buf_addr   (buf_addr),
        .buf_data   (buf_data),
        .busy       (busy),
        .frame_done (frame_done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One input cycle: drive at a falling edge, return at the next falling
    // edge, where the outputs reflect this cycle's byte.
    task automatic cyc_in(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    // Scoreboard: every buffer write must be the next expected pixel.
    always @(negedge clk) begin
        if (buf_we) begin
            if (exp_wr.size() == 0) begin
                check_eq("unexpected_write", {buf_we, buf_addr}, 64'd0);
            end else begin
                check_eq("write", {buf_addr, buf_data}, exp_wr.pop_front());
            end
        end
        if (frame_done) check_eq("done_on_last_write", {buf_we, buf_addr}, {1'b1, 19'(NPX - 1)});
        if (!tx_expected) check_eq("spurious_tx_valid", tx_valid, 64'd0);
        if (!tmo_expected) check_eq("spurious_timeout", timeout_err, 64'd0);
    end

    task automatic header(input bit double_sync);
        cyc_in(1'b1, S0);
        if (double_sync) cyc_in(1'b1, S0);
        cyc_in(1'b1, S1);
    endtask

    task automatic send_pixels(input int first, input int count, input bit addr_data, input int max_gap);
        logic [7:0] d;
        for (int a = first; a < first + count; a++) begin
            d = addr_data ? 8'(a) : 8'($urandom);
            repeat ($urandom_range(0, max_gap)) cyc_in(1'b0, 8'($urandom));
            exp_wr.push_back({19'(a), d});
            if (a == NPX - 1) tx_expected = 1'b1;
            cyc_in(1'b1, d);
        end
    endtask

    task automatic expect_reply(input logic [7:0] code, input int hold);
        for (int i = 0; i < hold; i++) begin
            tx_ready = 1'b0;
            cyc_in(1'b1, (i % 2 == 0) ? S0 : S1);
            check_eq("reply_hold", {tx_valid, tx_data, busy}, {1'b1, code, 1'b1});
        end
        tx_ready = 1'b1;
        cyc_in(1'b0, 8'h00);
        tx_ready = 1'b0;
        check_eq("reply_released", {tx_valid, busy}, 64'd0);
        tx_expected = 1'b0;
    endtask

    task automatic full_frame(input bit double_sync, input bit addr_data, input int max_gap, input int hold);
        header(double_sync);
        send_pixels(0, NPX, addr_data, max_gap);
        check_eq("frame_done_with_last", {frame_done, buf_we, tx_valid}, {1'b1, 1'b1, 1'b0});
        cyc_in(1'b0, 8'h00);
        check_eq("ack_after_done", {tx_valid, tx_data, frame_done, buf_we}, {1'b1, ACK_B, 1'b0, 1'b0});
        expect_reply(ACK_B, hold);
        check_eq("frame_fully_written", exp_wr.size(), 64'd0);
    endtask

    task automatic idle_noise(input int n);
        logic [7:0] d;
        for (int i = 0; i < n; i++) begin
            d = 8'($urandom);
            if (d == S0) d = 8'h00;
            cyc_in(1'($urandom), d);
        end
    endtask

    initial begin
        int n;
        bit found;
        rst = 1'b1; abort = 1'b0; tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        @(negedge clk);

        // Reset holds everything at zero whatever arrives on rx.
        for (int i = 0; i < 6; i++) begin
            cyc_in(1'($urandom), (i % 2 == 0) ? S0 : S1);
            check_eq("reset_outputs",
                     {tx_data, tx_valid, buf_we, buf_addr, buf_data, busy, frame_done, timeout_err},
                     64'd0);
        end
        rst = 1'b0;
        idle_noise(10);
        check_eq("idle_after_noise", busy, 64'd0);

        // Full frame with pixel value = address, back-to-back bytes, long reply hold.
        full_frame(1'b0, 1'b1, 0, 50);

        // Repeated first sync byte still starts a load; random gaps and data.
        full_frame(1'b1, 1'b0, 3, $urandom_range(0, 8));

        // Broken header: no load.
        cyc_in(1'b1, S0);
        check_eq("busy_after_sync0", busy, 64'd1);
        cyc_in(1'b1, 8'h33);
        check_eq("idle_after_bad_sync", busy, 64'd0);
        cyc_in(1'b1, S1);
        check_eq("sync1_alone_ignored", busy, 64'd0);
        idle_noise(12);

        // Silence after 10 pixels; the 10th arrives exactly on the terminal count.
        header(1'b0);
        send_pixels(0, 9, 1'b0, 50);
        repeat (TMO - 1) cyc_in(1'b0, 8'($urandom));
        send_pixels(9, 1, 1'b0, 0);
        check_eq("byte_beats_timeout", {timeout_err, buf_we}, {1'b0, 1'b1});
        tx_expected  = 1'b1;
        tmo_expected = 1'b1;
        n = 0;
        found = 1'b0;
        while (!found && n < 3 * TMO) begin
            cyc_in(1'b0, 8'h00);
            n++;
            if (timeout_err) found = 1'b1;
        end
        check_eq("timeout_latency", n, TMO);
        check_eq("no_tx_with_timeout", tx_valid, 64'd0);
        cyc_in(1'b0, 8'h00);
        tmo_expected = 1'b0;
        check_eq("nak_after_timeout", {tx_valid, tx_data, timeout_err}, {1'b1, NAK_B, 1'b0});
        expect_reply(NAK_B, 5);
        check_eq("partial_frame_written", exp_wr.size(), 64'd0);

        // Abort mid-load together with a byte: nothing written, no reply.
        header(1'b0);
        send_pixels(0, 20, 1'b0, 1);
        abort = 1'b1;
        cyc_in(1'b1, 8'hEE);
        abort = 1'b0;
        check_eq("abort_quiet", {buf_we, tx_valid, busy, frame_done, timeout_err}, 64'd0);
        repeat (TMO + 20) cyc_in(1'b0, 8'h00);
        full_frame(1'b0, 1'b0, 2, 3);

        // Reset mid-load, then a fresh frame starts at address 0.
        header(1'b0);
        send_pixels(0, 5, 1'b0, 0);
        rst = 1'b1;
        cyc_in(1'b1, 8'h77);
        rst = 1'b0;
        check_eq("reset_midload_quiet", {buf_we, busy, buf_addr}, 64'd0);
        full_frame(1'b0, 1'b1, 1, 2);

        // Abort while a reply is pending drops it.
        header(1'b0);
        send_pixels(0, NPX, 1'b0, 0);
        cyc_in(1'b0, 8'h00);
        check_eq("ack_before_abort", {tx_valid, tx_data}, {1'b1, ACK_B});
        abort = 1'b1;
        cyc_in(1'b0, 8'h00);
        abort = 1'b0;
        check_eq("abort_in_reply", {tx_valid, busy}, 64'd0);
        tx_expected = 1'b0;
        idle_noise(10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
